// File: rtl/uart_boot_loader.sv
// UART boot loader: 8N1 receiver plus framing FSM that writes an image into instruction BRAM.
// Optional inter-byte timeout is built only when BOOT_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------
// SYNC    | hunting for the 0xA5 preamble
// LEN_LO  | waiting for low byte of word count
// LEN_HI  | waiting for high byte of word count
// DATA    | receiving payload, one BRAM write per 4 bytes
// CSUM    | waiting for checksum byte
// DONE    | image verified, CPU released (until rst)
// ERR     | load failed, CPU held (until rst)
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 1024,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_line,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic        o_write,
    output logic        cpu_hold,
    output logic        boot_done,
    output logic        boot_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(MAX_WORDS) + 1;
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

    rx_state_t      rx_st, rx_nxt;
    state_t         state, state_nxt;
    logic           rx_meta, rx_s, rx_prev, rx_fall;
    logic [CW-1:0]  bit_tmr;
    logic           bit_tc;
    logic [2:0]     bit_cnt;
    logic [7:0]     rx_byte;
    logic           byte_valid, frame_err;
    logic [7:0]     len_lo, csum;
    logic [15:0]    len16;
    logic [IW-1:0]  n_words, idx;
    logic [1:0]     byte_k;
    logic [31:0]    word_sr;
    logic           active, last_word, tmo_hit;

    assign rx_fall   = rx_prev & ~rx_s;
    assign bit_tc    = (bit_tmr == '0);
    assign len16     = {rx_byte, len_lo};
    assign active    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
    assign last_word = (IW'(idx + IW'(1)) == n_words);
    assign cpu_hold  = (state != DONE);
    assign boot_done = (state == DONE);
    assign boot_err  = (state == ERR);

    always_comb begin
        rx_nxt     = rx_st;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_st)
            RX_IDLE:  if (rx_fall) rx_nxt = RX_START;
            RX_START: if (bit_tc) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tc && bit_cnt == 3'd7) rx_nxt = RX_STOP;
            RX_STOP: begin
                if (bit_tc) begin
                    rx_nxt     = RX_IDLE;
                    byte_valid = rx_s;
                    frame_err  = ~rx_s;
                end
            end
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            rx_st   <= RX_IDLE;
            bit_tmr <= HALF_BIT;
            bit_cnt <= 3'd0;
            rx_byte <= 8'h00;
        end else begin
            rx_meta <= rx_line;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            rx_st   <= rx_nxt;
            // Idle preloads the half-bit count so the start bit is checked mid-bit.
            if (rx_st == RX_IDLE)
                bit_tmr <= HALF_BIT;
            else if (bit_tc)
                bit_tmr <= FULL_BIT;
            else
                bit_tmr <= bit_tmr - CW'(1);
            if (rx_st == RX_IDLE)
                bit_cnt <= 3'd0;
            else if (rx_st == RX_DATA && bit_tc) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_byte <= {rx_s, rx_byte[7:1]};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:   if (byte_valid && rx_byte == 8'hA5) state_nxt = LEN_LO;
            LEN_LO: if (byte_valid) state_nxt = LEN_HI;
            LEN_HI: begin
                if (byte_valid) begin
                    if (len16 > 16'(MAX_WORDS))
                        state_nxt = ERR;
                    else if (len16 == 16'd0)
                        state_nxt = CSUM;
                    else
                        state_nxt = DATA;
                end
            end
            DATA:   if (byte_valid && byte_k == 2'd3 && last_word) state_nxt = CSUM;
            CSUM:   if (byte_valid) state_nxt = (rx_byte == csum) ? DONE : ERR;
            default: state_nxt = state;
        endcase
        if (active && (frame_err || tmo_hit))
            state_nxt = ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SYNC;
            o_addr  <= 32'd0;
            o_data  <= 32'd0;
            o_write <= 1'b0;
            len_lo  <= 8'h00;
            n_words <= '0;
            idx     <= '0;
            byte_k  <= 2'd0;
            csum    <= 8'h00;
            word_sr <= 32'd0;
        end else begin
            state   <= state_nxt;
            o_write <= 1'b0;
            if (byte_valid) begin
                case (state)
                    LEN_LO: len_lo  <= rx_byte;
                    LEN_HI: n_words <= IW'(len16);
                    DATA: begin
                        word_sr <= {rx_byte, word_sr[31:8]};
                        csum    <= csum ^ rx_byte;
                        byte_k  <= byte_k + 2'd1;
                        if (byte_k == 2'd3) begin
                            o_write <= 1'b1;
                            o_data  <= {rx_byte, word_sr[31:8]};
                            o_addr  <= 32'(idx) << 2;
                            idx     <= idx + IW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BOOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || !active || byte_valid)
            tmo_cnt <= TW'(TIMEOUT_CLKS - 1);
        else if (tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TW'(1);
    end

    assign tmo_hit = active && !byte_valid && (tmo_cnt == '0);
`else
    assign tmo_hit = 1'b0;
`endif

endmodule
